// File: rtl/x_corr_pkg.sv
// Shared types and helpers for the complex circular cross-correlator.
package x_corr_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Metric width: one bit above the wider accumulator so |I|+|Q| never overflows.
    function automatic int unsigned calc_w(input int unsigned i_bits, input int unsigned q_bits);
        return ((i_bits > q_bits) ? i_bits : q_bits) + 1;
    endfunction

endpackage

// File: rtl/x_corr_cmac.sv
// Complex multiply-accumulate of x*conj(y) into wrapping I/Q accumulators.
module x_corr_cmac
    import x_corr_pkg::*;
#(
    parameter int unsigned XI_BITS = 12,
    parameter int unsigned XQ_BITS = 12,
    parameter int unsigned YI_BITS = 12,
    parameter int unsigned YQ_BITS = 12,
    parameter int unsigned I_BITS  = 24,
    parameter int unsigned Q_BITS  = 24
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic signed [XI_BITS-1:0] i_xi,
    input  logic signed [XQ_BITS-1:0] i_xq,
    input  logic signed [YI_BITS-1:0] i_yi,
    input  logic signed [YQ_BITS-1:0] i_yq,
    output logic signed [I_BITS-1:0]  o_acc_i,
    output logic signed [Q_BITS-1:0]  o_acc_q
);

    logic signed [I_BITS-1:0] w_xi_i, w_xq_i, w_yi_i, w_yq_i;
    logic signed [Q_BITS-1:0] w_xi_q, w_xq_q, w_yi_q, w_yq_q;
    logic signed [I_BITS-1:0] w_prod_i;
    logic signed [Q_BITS-1:0] w_prod_q;
    logic signed [I_BITS-1:0] r_acc_i;
    logic signed [Q_BITS-1:0] r_acc_q;

    // Products are formed at accumulator width; modular arithmetic makes this exact mod 2^bits.
    always_comb begin
        w_xi_i   = I_BITS'(i_xi);
        w_xq_i   = I_BITS'(i_xq);
        w_yi_i   = I_BITS'(i_yi);
        w_yq_i   = I_BITS'(i_yq);
        w_xi_q   = Q_BITS'(i_xi);
        w_xq_q   = Q_BITS'(i_xq);
        w_yi_q   = Q_BITS'(i_yi);
        w_yq_q   = Q_BITS'(i_yq);
        w_prod_i = (w_xi_i * w_yi_i) + (w_xq_i * w_yq_i);
        w_prod_q = (w_xq_q * w_yi_q) - (w_xi_q * w_yq_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_clr) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
        end else if (i_en) begin
            r_acc_i <= r_acc_i + w_prod_i;
            r_acc_q <= r_acc_q + w_prod_q;
        end
    end

    assign o_acc_i = r_acc_i;
    assign o_acc_q = r_acc_q;

endmodule

// File: rtl/x_corr_engine.sv
// Block cross-correlator: buffers one block, sweeps every circular lag, reports peak |I|+|Q| and its lag.
module x_corr_engine
    import x_corr_pkg::*;
#(
    parameter int unsigned XI_BITS             = 12,
    parameter int unsigned XQ_BITS             = 12,
    parameter int unsigned YI_BITS             = 12,
    parameter int unsigned YQ_BITS             = 12,
    parameter int unsigned I_BITS              = 24,
    parameter int unsigned Q_BITS              = 24,
    parameter int unsigned LENGTH              = 5,
    parameter int unsigned LENGTH_COUNTER_BITS = 3,
    parameter int unsigned OUT_MAX_BITS        = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                m_axis_tvalid,
    input  logic signed [XI_BITS-1:0]           xi,
    input  logic signed [XQ_BITS-1:0]           xq,
    input  logic signed [YI_BITS-1:0]           yi,
    input  logic signed [YQ_BITS-1:0]           yq,
    output logic                                s_axis_tready,
    input  logic                                m_axis_tready,
    output logic                                s_axis_tvalid,
    output logic [OUT_MAX_BITS-1:0]             out_max,
    output logic [LENGTH_COUNTER_BITS-1:0]      index
);

    localparam int unsigned W   = calc_w(I_BITS, Q_BITS);
    localparam int unsigned LCB = LENGTH_COUNTER_BITS;
    localparam int unsigned CW  = LENGTH_COUNTER_BITS + 1;

    state_t r_state;

    logic [LCB-1:0]    r_n;
    logic [CW-1:0]     r_mac;
    logic [LCB-1:0]    r_k;
    logic [W-1:0]      r_best;
    logic [LCB-1:0]    r_best_idx;
    logic [OUT_MAX_BITS-1:0] r_out_max;
    logic [LCB-1:0]    r_index;
    logic              r_tvalid;
    logic              r_tready;

    logic signed [XI_BITS-1:0] r_xi [LENGTH];
    logic signed [XQ_BITS-1:0] r_xq [LENGTH];
    logic signed [YI_BITS-1:0] r_yi [LENGTH];
    logic signed [YQ_BITS-1:0] r_yq [LENGTH];

    logic              w_accept;
    logic              w_mac_en;
    logic              w_mac_clr;
    logic [CW-1:0]     w_m_sum;
    logic [LCB-1:0]    w_xidx;
    logic [LCB-1:0]    w_yidx;
    logic signed [I_BITS-1:0] w_acc_i;
    logic signed [Q_BITS-1:0] w_acc_q;
    logic signed [W-1:0] w_ext_i;
    logic signed [W-1:0] w_ext_q;
    logic [W-1:0]      w_abs_i;
    logic [W-1:0]      w_abs_q;
    logic [W-1:0]      w_metric;

    assign w_accept = (r_state == LOAD) && m_axis_tvalid;

    // Sample x[n] and y[(n+k) mod length]; the cycle at r_mac == length is the compare slot.
    always_comb begin
        w_mac_en  = (r_state == COMPUTE) && (r_mac < CW'(LENGTH));
        w_mac_clr = (r_state == COMPUTE) && (r_mac == CW'(LENGTH));
        w_m_sum   = r_mac + CW'(r_k);
        w_xidx    = '0;
        w_yidx    = '0;
        if (w_mac_en) begin
            w_xidx = LCB'(r_mac);
            if (w_m_sum >= CW'(LENGTH)) begin
                w_yidx = LCB'(w_m_sum - CW'(LENGTH));
            end else begin
                w_yidx = LCB'(w_m_sum);
            end
        end
    end

    x_corr_cmac #(
        .XI_BITS (XI_BITS),
        .XQ_BITS (XQ_BITS),
        .YI_BITS (YI_BITS),
        .YQ_BITS (YQ_BITS),
        .I_BITS  (I_BITS),
        .Q_BITS  (Q_BITS)
    ) u_cmac (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_mac_en),
        .i_clr   (w_mac_clr),
        .i_xi    (r_xi[w_xidx]),
        .i_xq    (r_xq[w_xidx]),
        .i_yi    (r_yi[w_yidx]),
        .i_yq    (r_yq[w_yidx]),
        .o_acc_i (w_acc_i),
        .o_acc_q (w_acc_q)
    );

    // |I| + |Q| at the widened metric width; the most negative accumulator value still fits.
    always_comb begin
        w_ext_i  = W'(w_acc_i);
        w_ext_q  = W'(w_acc_q);
        w_abs_i  = w_ext_i[W-1] ? W'(-w_ext_i) : W'(w_ext_i);
        w_abs_q  = w_ext_q[W-1] ? W'(-w_ext_q) : W'(w_ext_q);
        w_metric = w_abs_i + w_abs_q;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_xi[r_n] <= xi;
            r_xq[r_n] <= xq;
            r_yi[r_n] <= yi;
            r_yq[r_n] <= yq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LOAD;
            r_n        <= '0;
            r_mac      <= '0;
            r_k        <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_out_max  <= '0;
            r_index    <= '0;
            r_tvalid   <= 1'b0;
            r_tready   <= 1'b1;
        end else begin
            case (r_state)
                LOAD: begin
                    if (m_axis_tvalid) begin
                        if (r_n == LCB'(LENGTH - 1)) begin
                            r_n        <= '0;
                            r_mac      <= '0;
                            r_k        <= '0;
                            r_best     <= '0;
                            r_best_idx <= '0;
                            r_tready   <= 1'b0;
                            r_state    <= COMPUTE;
                        end else begin
                            r_n <= r_n + LCB'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (r_mac == CW'(LENGTH)) begin
                        r_mac <= '0;
                        // Strict compare: ties keep the earlier lag.
                        if (w_metric > r_best) begin
                            r_best     <= w_metric;
                            r_best_idx <= r_k;
                        end
                        if (r_k == LCB'(LENGTH - 1)) begin
                            r_k     <= '0;
                            r_state <= DONE;
                        end else begin
                            r_k <= r_k + LCB'(1);
                        end
                    end else begin
                        r_mac <= r_mac + CW'(1);
                    end
                end
                DONE: begin
                    if (!r_tvalid) begin
                        r_tvalid  <= 1'b1;
                        r_out_max <= r_best[W-1 -: OUT_MAX_BITS];
                        r_index   <= r_best_idx;
                    end else if (m_axis_tready) begin
                        r_tvalid <= 1'b0;
                        r_tready <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                default: begin
                    r_state  <= LOAD;
                    r_tvalid <= 1'b0;
                    r_tready <= 1'b1;
                end
            endcase
        end
    end

    assign s_axis_tready = r_tready;
    assign s_axis_tvalid = r_tvalid;
    assign out_max       = r_out_max;
    assign index         = r_index;

endmodule

// File: tb/tb_x_corr_engine.sv
// Directed self-checking bench for x_corr_engine.
module tb_x_corr_engine;

    logic               clk;
    logic               rst;
    logic               m_axis_tvalid;
    logic signed [11:0] xi, xq, yi, yq;
    logic               s_axis_tready;
    logic               m_axis_tready;
    logic               s_axis_tvalid;
    logic [4:0]         out_max;
    logic [2:0]         index;

    int errors = 0;
    int checks = 0;

    int v_xi[5];
    int v_xq[5];
    int v_yi[5];
    int v_yq[5];

    x_corr_engine dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tvalid (m_axis_tvalid),
        .xi            (xi),
        .xq            (xq),
        .yi            (yi),
        .yq            (yq),
        .s_axis_tready (s_axis_tready),
        .m_axis_tready (m_axis_tready),
        .s_axis_tvalid (s_axis_tvalid),
        .out_max       (out_max),
        .index         (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_vecs();
        for (int i = 0; i < 5; i++) begin
            v_xi[i] = 0; v_xq[i] = 0; v_yi[i] = 0; v_yq[i] = 0;
        end
    endtask

    task automatic set_vec(input int n, input int a, input int b, input int c, input int d);
        v_xi[n] = a; v_xq[n] = b; v_yi[n] = c; v_yq[n] = d;
    endtask

    // Feeds the current vectors; with gaps, an invalid cycle carrying junk precedes each sample.
    task automatic load_block(input bit gaps);
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_start: s_axis_tready=%b expected 1", s_axis_tready);
        end
        for (int i = 0; i < 5; i++) begin
            if (gaps) begin
                m_axis_tvalid = 1'b0;
                xi = 12'sd777; xq = -12'sd555; yi = 12'sd333; yq = 12'sd999;
                @(posedge clk); #1;
            end
            m_axis_tvalid = 1'b1;
            xi = 12'(v_xi[i]); xq = 12'(v_xq[i]); yi = 12'(v_yi[i]); yq = 12'(v_yq[i]);
            @(posedge clk); #1;
        end
        m_axis_tvalid = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop: s_axis_tready=%b expected 0", s_axis_tready);
        end
    endtask

    // Counts edges from the last accept edge until s_axis_tvalid is seen (bounded).
    task automatic wait_result(output int edges);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!s_axis_tvalid && edges < 200);
    endtask

    task automatic check_result(input string name, input int exp_max, input int exp_idx, input bit chk_lat);
        int edges;
        wait_result(edges);
        if (chk_lat) begin
            checks++;
            if (edges !== 31) begin
                errors++;
                $display("FAIL %s_latency: edges=%0d expected 31", name, edges);
            end
        end
        checks++;
        if (s_axis_tvalid !== 1'b1 || out_max !== 5'(exp_max) || index !== 3'(exp_idx)) begin
            errors++;
            $display("FAIL %s_result: valid=%b out_max=%0d index=%0d expected valid=1 out_max=%0d index=%0d",
                     name, s_axis_tvalid, out_max, index, exp_max, exp_idx);
        end
    endtask

    task automatic handshake(input string name, input int exp_max, input int exp_idx);
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        m_axis_tready = 1'b0;
        checks++;
        if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s_handshake: tvalid=%b tready=%b expected tvalid=0 tready=1",
                     name, s_axis_tvalid, s_axis_tready);
        end
        checks++;
        if (out_max !== 5'(exp_max) || index !== 3'(exp_idx)) begin
            errors++;
            $display("FAIL %s_retain: out_max=%0d index=%0d expected %0d %0d",
                     name, out_max, index, exp_max, exp_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        xi = '0; xq = '0; yi = '0; yq = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || out_max !== 5'd0 || index !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: tvalid=%b tready=%b out_max=%0d index=%0d expected 0 1 0 0",
                     s_axis_tvalid, s_axis_tready, out_max, index);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flat();
        clear_vecs();
        for (int i = 0; i < 5; i++) set_vec(i, 1000, 0, 1000, 0);
        load_block(1'b0);
        check_result("flat", 4, 0, 1'b1);
        handshake("flat", 4, 0);
    endtask

    task automatic test_impulse();
        clear_vecs();
        set_vec(0, 2000, 0, 0, 0);
        set_vec(2, 0, 0, 2000, 0);
        load_block(1'b0);
        check_result("impulse", 3, 2, 1'b1);
        handshake("impulse", 3, 2);
    endtask

    task automatic test_quadrature();
        clear_vecs();
        set_vec(0, 0, 2000, 2000, 0);
        load_block(1'b0);
        check_result("quad", 3, 0, 1'b1);
        handshake("quad", 3, 0);
    endtask

    // Negative Q with a wrapped lag: x[3]=(0,-2000), y[1]=(2000,0) peaks at k=3.
    task automatic test_neg_wrap();
        clear_vecs();
        set_vec(3, 0, -2000, 0, 0);
        set_vec(1, 0, 0, 2000, 0);
        load_block(1'b0);
        check_result("negwrap", 3, 3, 1'b1);
        handshake("negwrap", 3, 3);
    endtask

    task automatic test_backpressure();
        int bad;
        clear_vecs();
        set_vec(0, 2000, 0, 0, 0);
        set_vec(2, 0, 0, 2000, 0);
        load_block(1'b0);
        check_result("hold", 3, 2, 1'b0);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (s_axis_tvalid !== 1'b1 || s_axis_tready !== 1'b0 || out_max !== 5'd3 || index !== 3'd2) begin
                errors++;
                if (bad == 0)
                    $display("FAIL hold_stable: cycle=%0d tvalid=%b tready=%b out_max=%0d index=%0d expected 1 0 3 2",
                             c, s_axis_tvalid, s_axis_tready, out_max, index);
                bad++;
            end
        end
        handshake("hold", 3, 2);
    endtask

    task automatic test_gaps();
        clear_vecs();
        for (int i = 0; i < 5; i++) set_vec(i, -1000, 0, 1000, 0);
        load_block(1'b1);
        check_result("gaps", 4, 0, 1'b1);
        handshake("gaps", 4, 0);
    endtask

    task automatic test_abort();
        clear_vecs();
        set_vec(0, 2000, 0, 0, 0);
        set_vec(2, 0, 0, 2000, 0);
        load_block(1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (s_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 || out_max !== 5'd0 || index !== 3'd0) begin
            errors++;
            $display("FAIL abort_reset: tvalid=%b tready=%b out_max=%0d index=%0d expected 0 1 0 0",
                     s_axis_tvalid, s_axis_tready, out_max, index);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_vecs();
        set_vec(1, 0, 2000, 2000, 0);
        set_vec(4, 0, 0, 1000, 0);
        // Only n=1 nonzero in x; lag k with m=(1+k)%5: k=0 gives Q=4e6, k=3 gives Q=2e6.
        load_block(1'b0);
        check_result("abort_fresh", 3, 0, 1'b1);
        handshake("abort_fresh", 3, 0);
    endtask

    initial begin
        test_reset();
        test_flat();
        test_impulse();
        test_quadrature();
        test_neg_wrap();
        test_backpressure();
        test_gaps();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/x_corr_engine.md
Name: x_corr_engine

Overview:
- Complex circular cross-correlator over a block of `length` sample pairs (x, y).
- Buffers one block, computes the correlation at every lag, and reports the peak metric and the lag at which it occurs.
- Sits behind a frequency shifter inside a CAF slice; one instance per frequency bin.

Parameters:
- xi_bits, 12, width of signed x in-phase input
- xq_bits, 12, width of signed x quadrature input
- yi_bits, 12, width of signed y in-phase input
- yq_bits, 12, width of signed y quadrature input
- i_bits, 24, width of the signed I accumulator
- q_bits, 24, width of the signed Q accumulator
- length, 5, samples per block, which is also the number of lags
- length_counter_bits, 3, counter/index width; must satisfy 2^length_counter_bits >= length
- out_max_bits, 5, width of the reported peak metric

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- m_axis_tvalid  in  1  input sample valid
- xi  in  xi_bits  x in-phase, signed
- xq  in  xq_bits  x quadrature, signed
- yi  in  yi_bits  y in-phase, signed
- yq  in  yq_bits  y quadrature, signed
- s_axis_tready  out  1  ready to accept a sample
- m_axis_tready  in  1  downstream ready to take the result
- s_axis_tvalid  out  1  result valid
- out_max  out  out_max_bits  peak metric, truncated
- index  out  length_counter_bits  lag of the peak

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-high.
- Reset values: state=LOAD, all counters 0, accumulators 0, out_max=0, index=0, s_axis_tvalid=0.
- LOAD state:
  - s_axis_tready=1.
  - Each cycle with m_axis_tvalid=1 stores x[n] and y[n] into the buffers and increments n.
  - Accepting the sample at n=length-1 enters COMPUTE; s_axis_tready drops the following cycle.
  - Cycles with m_axis_tvalid=0 are ignored, and no partial block is emitted.
- COMPUTE state:
  - s_axis_tready=0.
  - For lags k=0..length-1, each lag takes length MAC cycles plus 1 compare cycle:
    - I += x_i[n]*y_i[m] + x_q[n]*y_q[m], with m=(n+k) mod length.
    - Q += x_q[n]*y_i[m] − x_i[n]*y_q[m] (this is x·conj(y)).
  - Products are full precision, sign-extended into i_bits/q_bits accumulators; accumulators wrap and do not saturate.
  - Compare cycle:
    - metric = |I| + |Q|, computed at width W = max(i_bits, q_bits)+1.
    - If metric is strictly greater than the best so far, the best and its lag are updated. Ties therefore keep the lowest lag.
    - Accumulators clear for the next lag.
  - The best so far is initialised to 0 at COMPUTE entry, so a block that correlates to all zeros reports index 0.
  - COMPUTE lasts exactly length*(length+1) cycles.
- DONE state:
  - s_axis_tvalid=1 starting on the edge after COMPUTE ends, i.e. length*(length+1)+1 edges after the last-accept edge (31 for length=5).
  - out_max = best_metric[W-1 -: out_max_bits]; index = best lag.
  - Both outputs are held stable while m_axis_tready=0.
  - A cycle with s_axis_tvalid && m_axis_tready returns the block to LOAD: s_axis_tvalid drops and s_axis_tready rises on the next edge.
  - out_max and index retain their values until the next result.
- rst asserted in any state aborts the current block immediately and returns to the reset values.
- Inputs arriving while s_axis_tready=0 are not consumed; the upstream must hold them.

Decomposition:
- Package x_corr_pkg holds the state enum {LOAD, COMPUTE, DONE} and a function that computes W from i_bits/q_bits.
- One natural sub-module: x_corr_cmac. It is the complex multiply-accumulate (x·conj(y)) with a clear input and I/Q accumulator outputs.

Test Plan:
- All 5 samples x=(1000,0) and y=(1000,0) → every lag metric 5,000,000; out_max=4, index=0 (tie keeps lowest lag); s_axis_tvalid rises 31 edges after the 5th accept.
- Impulses x[0]=(2000,0) and y[2]=(2000,0), all other samples 0 → peak I=4,000,000 at lag 2; out_max=3, index=2.
- x[0]=(0,2000) and y[0]=(2000,0), others 0 → I=0, Q=4,000,000; out_max=3, index=0.
- Hold m_axis_tready=0 for 20 cycles after valid → s_axis_tvalid, out_max and index stay stable and s_axis_tready=0. Releasing it gives one handshake, then s_axis_tready=1 next cycle.
- m_axis_tvalid toggling every other cycle during LOAD → only valid cycles are counted; same result as the contiguous case.
- Assert rst mid-COMPUTE → outputs return to 0 and s_axis_tready=1. A fresh block then yields the correct result, independent of the aborted block.
